// File: rtl/uart_pkg.sv
// Shared UART definitions: rx FSM state encoding, parity helper and the default
// clock/baud constants that the transmit path also uses.
package uart_pkg;

   localparam int DefaultClkFrequency = 25000000;
   localparam int DefaultBaud         = 115200;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_BREAK
   } rx_state_e;

   // Even parity: the parity bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick generator: a phase accumulator running at Baud*Oversampling,
// with a synchronous reload so the tick phase can be aligned to a start edge.
module uart_rx_tick_gen #(
   parameter int ClkFrequency = 25000000,
   parameter int Baud         = 115200,
   parameter int Oversampling = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic reload,
   output logic tick
);

   // 8 fractional bits beyond the integer clk-per-tick ratio keep drift well
   // inside the sampling window over a full frame.
   localparam int     AccWidth = $clog2(ClkFrequency / (Baud * Oversampling)) + 8;
   localparam longint IncFull  = ((longint'(Baud) * longint'(Oversampling)) * (longint'(1) << AccWidth)
                                  + longint'(ClkFrequency) / 2) / longint'(ClkFrequency);
   localparam logic [AccWidth:0] Inc = IncFull[AccWidth:0];

   logic [AccWidth-1:0] acc;
   logic [AccWidth:0]   sum;

   assign sum  = {1'b0, acc} + Inc;
   assign tick = enable & sum[AccWidth];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (reload) begin
         acc <= '0;
      end else if (enable) begin
         acc <= sum[AccWidth-1:0];
      end
   end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Oversampled, glitch-filtered receiver delivering bytes on a valid/ready stream.
module uart_rx_frontend
   import uart_pkg::*;
#(
   parameter int ClkFrequency = DefaultClkFrequency,
   parameter int Baud         = DefaultBaud,
   parameter int Oversampling = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RxD,
   output logic [7:0] RxD_data,
   output logic       RxD_data_valid,
   input  logic       RxD_data_ready,
   output logic       RxD_idle,
   output logic       RxD_frame_err,
   output logic       RxD_parity_err,
   output logic       RxD_overrun
);

   localparam logic [4:0] HalfBit    = 5'(Oversampling / 2);
   localparam logic [4:0] FullBit    = 5'(Oversampling);
   localparam logic [4:0] CentreLate = 5'(Oversampling + 1);

   rx_state_e  state, state_next;
   logic       rxd_meta, rxd_sync, rxd_prev, falling;
   logic       tick, tick_reload, tick_enable;
   logic [4:0] cnt, cnt_next, cnt_inc;
   logic [2:0] bit_idx, bit_idx_next;
   logic [7:0] shift, shift_next;
   logic [1:0] samp, samp_next;
   logic       majority, deliver, frame_set;
`ifdef UART_RX_PARITY_EN
   logic       par_err, par_err_next, parity_set;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_meta <= RxD;
         rxd_sync <= rxd_meta;
         rxd_prev <= rxd_sync;
      end
   end

   assign falling     = rxd_prev & ~rxd_sync;
   assign tick_enable = (state != RX_IDLE);
   assign cnt_inc     = cnt + 5'd1;
   // Two samples from the previous ticks plus the current one form the 2-of-3 vote.
   assign majority    = (samp[1] & samp[0]) | (samp[1] & rxd_sync) | (samp[0] & rxd_sync);
   assign RxD_idle    = (state == RX_IDLE) & rxd_sync;

   uart_rx_tick_gen #(
      .ClkFrequency(ClkFrequency),
      .Baud        (Baud),
      .Oversampling(Oversampling)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .enable(tick_enable),
      .reload(tick_reload),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         samp    <= '1;
`ifdef UART_RX_PARITY_EN
         par_err <= 1'b0;
`endif
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_idx <= bit_idx_next;
         shift   <= shift_next;
         samp    <= samp_next;
`ifdef UART_RX_PARITY_EN
         par_err <= par_err_next;
`endif
      end
   end

   // Bits are decided one tick past centre; the counter restarts at 1 so the
   // next centre stays Oversampling ticks after this one.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      bit_idx_next = bit_idx;
      shift_next   = shift;
      samp_next    = samp;
      tick_reload  = 1'b0;
      deliver      = 1'b0;
      frame_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_next = par_err;
      parity_set   = 1'b0;
`endif
      if (tick) samp_next = {samp[0], rxd_sync};
      case (state)
         RX_IDLE: begin
            if (falling) begin
               state_next   = RX_START;
               cnt_next     = '0;
               bit_idx_next = '0;
               tick_reload  = 1'b1;
`ifdef UART_RX_PARITY_EN
               par_err_next = 1'b0;
`endif
            end
         end
         RX_START: begin
            if (tick) begin
               cnt_next = cnt_inc;
               if (cnt_inc == HalfBit) begin
                  cnt_next   = '0;
                  state_next = rxd_sync ? RX_IDLE : RX_DATA;
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               cnt_next = cnt_inc;
               if (cnt_inc == CentreLate) begin
                  cnt_next     = 5'd1;
                  shift_next   = {majority, shift[7:1]};
                  bit_idx_next = bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_next = RX_PARITY;
`else
                     state_next = RX_STOP;
`endif
                  end
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         RX_PARITY: begin
            if (tick) begin
               cnt_next = cnt_inc;
               if (cnt_inc == CentreLate) begin
                  cnt_next     = 5'd1;
                  par_err_next = (majority != even_parity(shift));
                  state_next   = RX_STOP;
               end
            end
         end
`endif
         RX_STOP: begin
            if (tick) begin
               cnt_next = cnt_inc;
               if (cnt_inc == CentreLate) begin
                  cnt_next = '0;
                  if (majority) begin
`ifdef UART_RX_PARITY_EN
                     parity_set = par_err;
                     deliver    = ~par_err;
`else
                     deliver    = 1'b1;
`endif
                     state_next = RX_IDLE;
                  end else begin
                     frame_set  = 1'b1;
                     state_next = RX_BREAK;
                  end
               end
            end
         end
         RX_BREAK: begin
            if (tick) begin
               if (rxd_sync) begin
                  cnt_next = cnt_inc;
                  if (cnt_inc == FullBit) begin
                     cnt_next   = '0;
                     state_next = RX_IDLE;
                  end
               end else begin
                  cnt_next = '0;
               end
            end
         end
         default: state_next = RX_IDLE;
      endcase
   end

   // A byte only displaces the held one when the consumer takes it in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RxD_data       <= 8'h00;
         RxD_data_valid <= 1'b0;
         RxD_frame_err  <= 1'b0;
         RxD_overrun    <= 1'b0;
      end else begin
         RxD_frame_err <= frame_set;
         RxD_overrun   <= deliver & RxD_data_valid & ~RxD_data_ready;
         if (deliver && (!RxD_data_valid || RxD_data_ready)) begin
            RxD_data       <= shift;
            RxD_data_valid <= 1'b1;
         end else if (RxD_data_valid && RxD_data_ready) begin
            RxD_data_valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) RxD_parity_err <= 1'b0;
      else     RxD_parity_err <= parity_set;
   end
`else
   assign RxD_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at 25 MHz / 115200 baud / 8x oversampling.
// Follows UART_RX_PARITY_EN to choose 8N1 or 8E1 framing.
module tb_uart_rx_frontend;

   localparam int BitClks = 217;
`ifdef UART_RX_PARITY_EN
   localparam int FrameBits   = 10;
   localparam int DeliverEdge = 2308;
`else
   localparam int FrameBits   = 9;
   localparam int DeliverEdge = 2091;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       RxD = 1'b1;
   logic       RxD_data_ready = 1'b1;
   logic [7:0] RxD_data;
   logic       RxD_data_valid, RxD_idle, RxD_frame_err, RxD_parity_err, RxD_overrun;

   int compared = 0;
   int mismatched = 0;
   int valid_cycles = 0, frame_cycles = 0, parity_cycles = 0, overrun_cycles = 0;
   int b_valid, b_frame, b_parity, b_overrun;
   logic [7:0] pattern;

   uart_rx_frontend dut (
      .clk           (clk),
      .rst           (rst),
      .RxD           (RxD),
      .RxD_data      (RxD_data),
      .RxD_data_valid(RxD_data_valid),
      .RxD_data_ready(RxD_data_ready),
      .RxD_idle      (RxD_idle),
      .RxD_frame_err (RxD_frame_err),
      .RxD_parity_err(RxD_parity_err),
      .RxD_overrun   (RxD_overrun)
   );

   always #20 clk = ~clk;

   // Cycle counters for the stream handshake and every error pulse.
   always @(negedge clk) begin
      if (RxD_data_valid) valid_cycles++;
      if (RxD_frame_err)  frame_cycles++;
      if (RxD_parity_err) parity_cycles++;
      if (RxD_overrun)    overrun_cycles++;
   end

   function automatic logic [11:0] frameBits(input logic [7:0] data, input logic stop_bit);
`ifdef UART_RX_PARITY_EN
      return {2'b11, stop_bit, ^data, data};
`else
      return {3'b111, stop_bit, data};
`endif
   endfunction

   task automatic applyStimulus(input logic [11:0] bits, input int nbits);
      @(negedge clk);
      RxD = 1'b0;
      repeat (BitClks) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         RxD = bits[i];
         repeat (BitClks) @(negedge clk);
      end
   endtask

   task automatic sendByte(input logic [7:0] data);
      applyStimulus(frameBits(data, 1'b1), FrameBits);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic snapshot();
      @(posedge clk);
      #1;
      b_valid   = valid_cycles;
      b_frame   = frame_cycles;
      b_parity  = parity_cycles;
      b_overrun = overrun_cycles;
   endtask

   task automatic settle(input int cycles);
      repeat (cycles) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      $display("[TB] start");
      settle(5);
      checkOutput("reset_data",   32'(RxD_data),       32'h00);
      checkOutput("reset_valid",  32'(RxD_data_valid), 32'h0);
      checkOutput("reset_idle",   32'(RxD_idle),       32'h1);
      checkOutput("reset_frame",  32'(RxD_frame_err),  32'h0);
      checkOutput("reset_parity", 32'(RxD_parity_err), 32'h0);
      checkOutput("reset_overrun",32'(RxD_overrun),    32'h0);
      rst = 1'b0;
      settle(10);

      $display("[TB] reset during bit 3 of 0xA5");
      snapshot();
      pattern = 8'hA5;
      @(negedge clk);
      RxD = 1'b0;
      repeat (BitClks) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         RxD = pattern[i];
         repeat (BitClks) @(negedge clk);
      end
      RxD = pattern[3];
      repeat (100) @(negedge clk);
      rst = 1'b1;
      RxD = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      settle(2 * BitClks);
      checkOutput("midrst_valid", valid_cycles - b_valid, 0);
      checkOutput("midrst_idle",  32'(RxD_idle), 32'h1);
      snapshot();
      sendByte(8'h3C);
      settle(20);
      checkOutput("midrst_3c_valid", valid_cycles - b_valid, 1);
      checkOutput("midrst_3c_data",  32'(RxD_data), 32'h3C);

      $display("[TB] single byte 0x55");
      snapshot();
      sendByte(8'h55);
      settle(20);
      checkOutput("single_valid_cycles", valid_cycles - b_valid, 1);
      checkOutput("single_data",         32'(RxD_data), 32'h55);
      checkOutput("single_frame",        frame_cycles - b_frame, 0);
      checkOutput("single_parity",       parity_cycles - b_parity, 0);
      checkOutput("single_overrun",      overrun_cycles - b_overrun, 0);

      $display("[TB] 40-clk start glitch");
      snapshot();
      @(negedge clk);
      RxD = 1'b0;
      repeat (40) @(negedge clk);
      RxD = 1'b1;
      settle(300);
      checkOutput("glitch_valid", valid_cycles - b_valid, 0);
      checkOutput("glitch_frame", frame_cycles - b_frame, 0);
      checkOutput("glitch_idle",  32'(RxD_idle), 32'h1);

      $display("[TB] framing error on 0xF0");
      snapshot();
      applyStimulus(frameBits(8'hF0, 1'b0), FrameBits);
      settle(100);
      checkOutput("frame_pulse", frame_cycles - b_frame, 1);
      checkOutput("frame_valid", valid_cycles - b_valid, 0);
      checkOutput("break_idle",  32'(RxD_idle), 32'h0);
      RxD = 1'b1;
      settle(BitClks + 60);
      checkOutput("break_exit_idle", 32'(RxD_idle), 32'h1);
      snapshot();
      sendByte(8'h0F);
      settle(20);
      checkOutput("after_break_valid", valid_cycles - b_valid, 1);
      checkOutput("after_break_data",  32'(RxD_data), 32'h0F);

      $display("[TB] overrun with ready low");
      RxD_data_ready = 1'b0;
      snapshot();
      sendByte(8'h11);
      sendByte(8'h22);
      settle(50);
      checkOutput("overrun_pulse", overrun_cycles - b_overrun, 1);
      checkOutput("overrun_data",  32'(RxD_data), 32'h11);
      checkOutput("overrun_valid", 32'(RxD_data_valid), 32'h1);

      $display("[TB] ready raised on the delivery cycle");
      snapshot();
      fork
         sendByte(8'h22);
         begin
            @(negedge RxD);
            repeat (DeliverEdge) @(posedge clk);
            @(negedge clk);
            RxD_data_ready = 1'b1;
            @(negedge clk);
            RxD_data_ready = 1'b0;
         end
      join
      settle(20);
      checkOutput("replace_overrun", overrun_cycles - b_overrun, 0);
      checkOutput("replace_data",    32'(RxD_data), 32'h22);
      checkOutput("replace_valid",   32'(RxD_data_valid), 32'h1);
      RxD_data_ready = 1'b1;
      settle(3);
      checkOutput("consume_valid", 32'(RxD_data_valid), 32'h0);
      checkOutput("consume_data",  32'(RxD_data), 32'h22);

`ifdef UART_RX_PARITY_EN
      $display("[TB] parity on 0x03");
      snapshot();
      applyStimulus({2'b11, 1'b1, 1'b1, 8'h03}, FrameBits);
      settle(20);
      checkOutput("parity_bad_pulse", parity_cycles - b_parity, 1);
      checkOutput("parity_bad_valid", valid_cycles - b_valid, 0);
      snapshot();
      applyStimulus({2'b11, 1'b1, 1'b0, 8'h03}, FrameBits);
      settle(20);
      checkOutput("parity_good_valid", valid_cycles - b_valid, 1);
      checkOutput("parity_good_data",  32'(RxD_data), 32'h03);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
